// File: rtl/output_channel_pkg.sv
// Shared definitions for the switch output channel: default geometry,
// flit framing bit positions and FSM state encodings.
package output_channel_pkg;

   localparam int DEF_DATA_WIDTH      = 70;
   localparam int DEF_NUMBER_CHANNELS = 5;
   localparam int DEF_FIFO_DEPTH      = 4;
   localparam int DEF_FIFO_WIDTH      = 2;

   // Framing bits for the default flit width
   localparam int BOP_BIT = DEF_DATA_WIDTH - 1;
   localparam int EOP_BIT = DEF_DATA_WIDTH - 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   // Framing bit positions for an arbitrary flit width
   function automatic int bop_pos(input int width);
      return width - 1;
   endfunction

   function automatic int eop_pos(input int width);
      return width - 2;
   endfunction

endpackage

// File: rtl/output_channel_if.sv
// Bundle of the input-side grant/pop handshake and the downstream val/ack link.
// slave = the output channel itself, master = whoever drives the inputs.
interface output_channel_if
   import output_channel_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int NUMBER_CHANNELS = DEF_NUMBER_CHANNELS
);

   logic [NUMBER_CHANNELS-1:0]            x_req;
   logic [NUMBER_CHANNELS-1:0]            x_rok;
   logic [DATA_WIDTH*NUMBER_CHANNELS-1:0] x_din;
   logic [NUMBER_CHANNELS-1:0]            x_gnt;
   logic [NUMBER_CHANNELS-1:0]            x_ack;
   logic [DATA_WIDTH-1:0]                 out_data;
   logic                                  out_val;
   logic                                  out_ack;

   modport slave (
      input  x_req, x_rok, x_din, out_ack,
      output x_gnt, x_ack, out_data, out_val
   );

   modport master (
      output x_req, x_rok, x_din, out_ack,
      input  x_gnt, x_ack, out_data, out_val
   );

endinterface

// File: rtl/output_channel_rr_arbiter.sv
// Round-robin requester selection: first asserted request at or after ptr,
// wrapping modulo NUMBER_CHANNELS. Purely combinational.
module output_rr_arbiter #(
   parameter int NUMBER_CHANNELS = 5,
   parameter int PTR_W           = 3
) (
   input  logic [NUMBER_CHANNELS-1:0] req,
   input  logic [PTR_W-1:0]           ptr,
   output logic [NUMBER_CHANNELS-1:0] gnt,
   output logic [PTR_W-1:0]           sel,
   output logic                       any
);

   // Scan requesters starting from the priority pointer; first hit wins
   always_comb begin
      int idx;
      idx = 0;
      gnt = '0;
      sel = '0;
      any = 1'b0;
      for (int off = 0; off < NUMBER_CHANNELS; off++) begin
         idx = (int'(ptr) + off) % NUMBER_CHANNELS;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            sel      = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/output_channel.sv
// Switch output stage: round-robin packet arbitration across the input
// channels' per-output FIFOs, flit transfer from the granted FIFO into a
// small output buffer, and val/ack delivery to the next hop.
module output_channel
   import output_channel_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int NUMBER_CHANNELS = DEF_NUMBER_CHANNELS,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int FIFO_WIDTH      = DEF_FIFO_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   output_channel_if.slave  bus
);

   localparam int PTR_W   = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;
   localparam int EOP_POS = eop_pos(DATA_WIDTH);

   // Arbitration / grant state
   state_e                     state_q, state_d;
   logic [NUMBER_CHANNELS-1:0] gnt_q, gnt_d;
   logic [PTR_W-1:0]           sel_q, sel_d;
   logic [PTR_W-1:0]           ptr_q, ptr_d;

   // Output buffer state
   logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
   logic [FIFO_WIDTH-1:0]                 wr_q, wr_d;
   logic [FIFO_WIDTH-1:0]                 rd_q, rd_d;
   logic [FIFO_WIDTH:0]                   cnt_q, cnt_d;

   logic [NUMBER_CHANNELS-1:0] arb_gnt;
   logic [PTR_W-1:0]           arb_sel;
   logic                       arb_any;
   logic [NUMBER_CHANNELS-1:0] ack_vec;
   logic [DATA_WIDTH-1:0]      head;
   logic                       full, empty;
   logic                       push, out_pop;

   output_rr_arbiter #(
      .NUMBER_CHANNELS (NUMBER_CHANNELS),
      .PTR_W           (PTR_W)
   ) u_arb (
      .req (bus.x_req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .sel (arb_sel),
      .any (arb_any)
   );

   assign full    = (cnt_q == (FIFO_WIDTH+1)'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = bus.x_din[sel_q*DATA_WIDTH +: DATA_WIDTH];
   // Push is gated only by full: a same-cycle downstream pop does not open a slot
   assign push    = (state_q == ST_XFER) && bus.x_rok[sel_q] && !full;
   assign out_pop = !empty && bus.out_ack;

   // Grant FSM: pick a packet in IDLE, hold the grant until its EOP flit is popped
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      ack_vec = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d   = arb_gnt;
               sel_d   = arb_sel;
               state_d = ST_XFER;
            end else begin
               gnt_d = '0;
            end
         end
         ST_XFER: begin
            if (push) begin
               ack_vec[sel_q] = 1'b1;
               if (head[EOP_POS]) begin
                  gnt_d   = '0;
                  state_d = ST_IDLE;
                  ptr_d   = (sel_q == PTR_W'(NUMBER_CHANNELS-1)) ? '0 : sel_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Output buffer: write popped flit, advance pointers, track occupancy
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = head;
         wr_d        = wr_q + 1'b1;
      end
      if (out_pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push, out_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers with synchronous reset; a reset drops any partial packet
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.x_gnt    = gnt_q;
   assign bus.x_ack    = ack_vec;
   assign bus.out_val  = !empty;
   assign bus.out_data = empty ? '0 : mem_q[rd_q];

endmodule

// File: tb/tb_output_channel.sv
// Directed bench for output_channel: input FIFOs modelled as queues that pop
// on x_ack, downstream flits collected and compared against send order.
module tb_output_channel;
   import output_channel_pkg::*;

   localparam int DW = 70;
   localparam int NC = 5;

   typedef logic [DW-1:0] flit_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_channel_if #(.DATA_WIDTH(DW), .NUMBER_CHANNELS(NC)) bus ();

   output_channel #(
      .DATA_WIDTH      (DW),
      .NUMBER_CHANNELS (NC),
      .FIFO_DEPTH      (4),
      .FIFO_WIDTH      (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   flit_t          inq [NC][$];
   flit_t          rxq [$];
   flit_t          expq[$];
   logic [NC-1:0]  rok_mask;
   int             ack_cnt[NC];
   int             n_cmp = 0;
   int             n_bad = 0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic flit_t mk(input bit bop, input bit eop, input int ch, input int idx);
      flit_t f;
      f         = '0;
      f[DW-1]   = bop;
      f[DW-2]   = eop;
      f[15:0]   = 16'(ch*256 + idx);
      return f;
   endfunction

   task automatic push_pkt(input int ch, input int n, input int base);
      for (int k = 0; k < n; k++) begin
         inq[ch].push_back(mk(k == 0, k == n-1, ch, base+k));
         expq.push_back(mk(k == 0, k == n-1, ch, base+k));
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < NC; i++) begin
         bus.x_req[i]            = (inq[i].size() != 0);
         bus.x_rok[i]            = (inq[i].size() != 0) && !rok_mask[i];
         bus.x_din[i*DW +: DW]   = (inq[i].size() != 0) ? inq[i][0] : '0;
      end
   endtask

   // One clock: sample handshakes mid-cycle, cross the edge, update input queues
   task automatic tick();
      logic [NC-1:0] acks;
      refresh();
      #1;
      acks = bus.x_ack;
      if (!rst) begin
         for (int i = 0; i < NC; i++) if (acks[i]) ack_cnt[i]++;
         if (bus.out_val && bus.out_ack) rxq.push_back(bus.out_data);
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int i = 0; i < NC; i++) if (acks[i] && inq[i].size() != 0) void'(inq[i].pop_front());
      end
      refresh();
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NC; i++) begin
         inq[i].delete();
         ack_cnt[i] = 0;
      end
      rxq.delete();
      expq.delete();
      rok_mask = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_rx_cnt"}, rxq.size(), expq.size());
      for (int k = 0; k < expq.size(); k++)
         if (k < rxq.size()) check({tag, "_rx_data"}, rxq[k], expq[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      rok_mask    = '0;
      bus.x_req   = '0;
      bus.x_rok   = '0;
      bus.x_din   = '0;
      bus.out_ack = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state
      check("rst_gnt",  bus.x_gnt,    0);
      check("rst_ack",  bus.x_ack,    0);
      check("rst_val",  bus.out_val,  0);
      check("rst_data", bus.out_data, 0);

      // 1: ch2 three-flit packet, downstream always ready
      push_pkt(2, 3, 0);
      refresh();
      #1;
      check("t1_gnt_pre", bus.x_gnt, 0);
      tick();
      check("t1_gnt", bus.x_gnt, 5'b00100);
      check("t1_ack", bus.x_ack, 5'b00100);
      for (int n = 0; n < 10 && bus.x_gnt != 0; n++) tick();
      check("t1_gnt_end", bus.x_gnt, 0);
      check("t1_ack_cnt", ack_cnt[2], 3);
      repeat (3) tick();
      compare_rx("t1");

      // 2: ch0/1/4 single flits, round-robin order then wrap back to ch0
      do_reset();
      push_pkt(0, 1, 0);
      push_pkt(1, 1, 0);
      push_pkt(4, 1, 0);
      tick(); check("t2_g0",    bus.x_gnt, 5'b00001);
      tick(); check("t2_idle0", bus.x_gnt, 5'b00000);
      tick(); check("t2_g1",    bus.x_gnt, 5'b00010);
      tick(); check("t2_idle1", bus.x_gnt, 5'b00000);
      tick(); check("t2_g4",    bus.x_gnt, 5'b10000);
      tick(); check("t2_idle4", bus.x_gnt, 5'b00000);
      push_pkt(0, 1, 1);
      push_pkt(4, 1, 1);
      tick(); check("t2_wrap0", bus.x_gnt, 5'b00001);
      tick(); check("t2_idle5", bus.x_gnt, 5'b00000);
      tick(); check("t2_g4b",   bus.x_gnt, 5'b10000);
      repeat (4) tick();
      compare_rx("t2");

      // 3: downstream stall fills the buffer, then drains
      do_reset();
      bus.out_ack = 1'b0;
      push_pkt(3, 6, 0);
      tick();
      check("t3_gnt", bus.x_gnt, 5'b01000);
      repeat (8) tick();
      check("t3_pops",      ack_cnt[3],   4);
      check("t3_ack_stall", bus.x_ack,    0);
      check("t3_val",       bus.out_val,  1);
      check("t3_gnt_hold",  bus.x_gnt,    5'b01000);
      check("t3_head",      bus.out_data, mk(1, 0, 3, 0));
      bus.out_ack = 1'b1;
      for (int n = 0; n < 20 && bus.x_gnt != 0; n++) tick();
      check("t3_gnt_end", bus.x_gnt, 0);
      repeat (6) tick();
      check("t3_pops_all", ack_cnt[3], 6);
      compare_rx("t3");

      // 4: input FIFO runs dry mid-packet
      do_reset();
      push_pkt(1, 4, 0);
      tick();
      check("t4_gnt", bus.x_gnt, 5'b00010);
      tick();
      tick();
      rok_mask = 5'b00010;
      refresh();
      #1;
      check("t4_ack_dry0", bus.x_ack, 0);
      tick();
      check("t4_ack_dry1", bus.x_ack, 0);
      check("t4_gnt_dry",  bus.x_gnt, 5'b00010);
      tick();
      check("t4_no_bubble", bus.out_val, 0);
      check("t4_rx_mid",    rxq.size(),  2);
      rok_mask = '0;
      for (int n = 0; n < 10 && bus.x_gnt != 0; n++) tick();
      check("t4_gnt_end", bus.x_gnt, 0);
      repeat (3) tick();
      compare_rx("t4");

      // 5: next request arrives on the EOP pop cycle
      do_reset();
      push_pkt(0, 1, 0);
      tick();
      check("t5_g0", bus.x_gnt, 5'b00001);
      push_pkt(1, 1, 0);
      refresh();
      #1;
      check("t5_ack0", bus.x_ack, 5'b00001);
      tick(); check("t5_gap", bus.x_gnt, 5'b00000);
      tick(); check("t5_g1",  bus.x_gnt, 5'b00010);
      tick(); check("t5_end", bus.x_gnt, 5'b00000);
      repeat (3) tick();
      compare_rx("t5");

      // 6: reset mid-packet with pointer left at 2 by test 5
      bus.out_ack = 1'b0;
      push_pkt(2, 4, 0);
      tick();
      check("t6_gnt", bus.x_gnt, 5'b00100);
      tick();
      check("t6_val_pre", bus.out_val, 1);
      check("t6_ack_f2",  bus.x_ack,   5'b00100);
      rst = 1'b1;
      clear_model();
      tick();
      check("t6_rst_gnt",  bus.x_gnt,    0);
      check("t6_rst_val",  bus.out_val,  0);
      check("t6_rst_data", bus.out_data, 0);
      check("t6_rst_ack",  bus.x_ack,    0);
      rst = 1'b0;
      push_pkt(1, 1, 0);
      push_pkt(4, 1, 0);
      tick();
      check("t6_ptr0", bus.x_gnt, 5'b00010);
      bus.out_ack = 1'b1;
      repeat (8) tick();
      compare_rx("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
